// File: rtl/qed_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qed_pkg                                                                  |
// | Shared types, defaults and helpers for the SQED execution scheduler.     |
// |   qed_state_t  : scheduler phase encoding                                |
// |   QED_CNT_W    : default width of the original/duplicate counters        |
// |   QED_MAX_ORIG : default maximum number of originals per round           |
// |   popcount2    : number of set bits in a two-slot mask                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package qed_pkg;

   localparam int QED_CNT_W    = 5;
   localparam int QED_MAX_ORIG = 16;

   typedef enum logic [2:0] {
      ORIG  = 3'd0,
      DUP   = 3'd1,
      DRAIN = 3'd2,
      CHECK = 3'd3,
      ABORT = 3'd4
   } qed_state_t;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/qed_slot_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qed_slot_alloc                                                           |
// | Combinational two-slot grant logic. Slot 0 is served first; slot 1 is    |
// | granted only if capacity is left after slot 0, which keeps program order.|
// |   valid    in  2  per-slot candidate present                             |
// |   ready    in  1  downstream can take instructions (already gated)       |
// |   capacity in  W  number of slots still allowed this round               |
// |   grant    out 2  per-slot grant                                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module qed_slot_alloc #(
   parameter int W = 5
) (
   input  logic [1:0]   valid,
   input  logic         ready,
   input  logic [W-1:0] capacity,
   output logic [1:0]   grant
);

   logic cap_ge1;
   logic cap_ge2;

   assign cap_ge1 = (capacity != '0);
   assign cap_ge2 = (capacity > W'(1));

   assign grant[0] = ready & valid[0] & cap_ge1;
   // Slot 1 needs one more unit of capacity when slot 0 consumed one.
   assign grant[1] = ready & valid[1] & (grant[0] ? cap_ge2 : cap_ge1);

endmodule
`default_nettype wire

// File: rtl/qed_exec_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qed_exec_scheduler                                                       |
// | Sequences an SQED round on the dual-issue pipe: accept originals, replay |
// | their duplicates, wait for commit drain, then pulse the check window.    |
// |   clk, reset_x (async, active-low)                                       |
// |   slot_valid[1:0], orig_ready, dup_ready, exec_dup_req, rob_empty,       |
// |   pipe_flush                                      : inputs               |
// |   orig_accept[1:0], dup_issue[1:0]                : combinational grants |
// |   qed_exec_dup, num_orig_insts, num_dup_insts,                           |
// |   wait_till_commit, chk_en, abort                 : registered status    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module qed_exec_scheduler
   import qed_pkg::*;
#(
   parameter int CNT_W    = QED_CNT_W,
   parameter int MAX_ORIG = QED_MAX_ORIG
) (
   input  logic             clk,
   input  logic             reset_x,
   input  logic [1:0]       slot_valid,
   input  logic             orig_ready,
   input  logic             dup_ready,
   input  logic             exec_dup_req,
   input  logic             rob_empty,
   input  logic             pipe_flush,
   output logic [1:0]       orig_accept,
   output logic [1:0]       dup_issue,
   output logic             qed_exec_dup,
   output logic [CNT_W-1:0] num_orig_insts,
   output logic [CNT_W-1:0] num_dup_insts,
   output logic             wait_till_commit,
   output logic             chk_en,
   output logic             abort
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ORIG);

   qed_state_t       state;
   qed_state_t       state_nxt;
   logic [CNT_W-1:0] orig_cap;
   logic [CNT_W-1:0] dup_rem;
   logic [CNT_W-1:0] num_orig_nxt;
   logic [CNT_W-1:0] num_dup_nxt;
   logic             orig_go;
   logic             dup_go;

   // A flush cycle never accepts or issues anything.
   assign orig_go  = orig_ready & (state == ORIG) & ~pipe_flush;
   assign dup_go   = dup_ready  & (state == DUP)  & ~pipe_flush;
   assign orig_cap = MAX_C - num_orig_insts;
   assign dup_rem  = num_orig_insts - num_dup_insts;

   qed_slot_alloc #(.W(CNT_W)) u_orig_alloc (
      .valid    (slot_valid),
      .ready    (orig_go),
      .capacity (orig_cap),
      .grant    (orig_accept)
   );

   // Duplicates always exist in the QED i-cache for both slots; the
   // remaining count alone limits the issue width.
   qed_slot_alloc #(.W(CNT_W)) u_dup_alloc (
      .valid    (2'b11),
      .ready    (dup_go),
      .capacity (dup_rem),
      .grant    (dup_issue)
   );

   always_comb begin
      state_nxt    = state;
      num_orig_nxt = num_orig_insts + {{(CNT_W-2){1'b0}}, popcount2(orig_accept)};
      num_dup_nxt  = num_dup_insts  + {{(CNT_W-2){1'b0}}, popcount2(dup_issue)};
      case (state)
         ORIG: begin
            if (pipe_flush)
               state_nxt = ABORT;
            else if ((num_orig_nxt != '0) &&
                     (exec_dup_req || (num_orig_nxt == MAX_C)))
               state_nxt = DUP;
         end
         DUP: begin
            if (pipe_flush)
               state_nxt = ABORT;
            else if (num_dup_nxt == num_orig_insts)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (pipe_flush)
               state_nxt = ABORT;
            else if (rob_empty)
               state_nxt = CHECK;
         end
         CHECK:   state_nxt = ORIG;
         ABORT:   state_nxt = ORIG;
         default: state_nxt = ORIG;
      endcase
      // Counters hold through CHECK and clear when a round ends or is dropped.
      if ((state_nxt == ABORT) || (state == CHECK) || (state == ABORT)) begin
         num_orig_nxt = '0;
         num_dup_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state            <= ORIG;
         num_orig_insts   <= '0;
         num_dup_insts    <= '0;
         qed_exec_dup     <= 1'b0;
         wait_till_commit <= 1'b0;
         chk_en           <= 1'b0;
         abort            <= 1'b0;
      end else begin
         state            <= state_nxt;
         num_orig_insts   <= num_orig_nxt;
         num_dup_insts    <= num_dup_nxt;
         qed_exec_dup     <= (state_nxt == DUP) || (state_nxt == DRAIN) ||
                             (state_nxt == CHECK);
         wait_till_commit <= (state_nxt == DRAIN) || (state_nxt == CHECK);
         chk_en           <= (state_nxt == CHECK);
         abort            <= (state_nxt == ABORT);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_qed_exec_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qed_exec_scheduler                                                    |
// | Directed vector bench for qed_exec_scheduler: a table of per-cycle       |
// | inputs with expected grants and post-edge registered outputs, plus hand  |
// | sequences for saturation, capacity boundary, flush and async reset.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_qed_exec_scheduler;

   logic       clk = 1'b0;
   logic       reset_x;
   logic [1:0] slot_valid;
   logic       orig_ready, dup_ready, exec_dup_req, rob_empty, pipe_flush;
   logic [1:0] orig_accept, dup_issue;
   logic       qed_exec_dup, wait_till_commit, chk_en, abort;
   logic [4:0] num_orig_insts, num_dup_insts;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   qed_exec_scheduler #(.CNT_W(5), .MAX_ORIG(16)) dut (
      .clk              (clk),
      .reset_x          (reset_x),
      .slot_valid       (slot_valid),
      .orig_ready       (orig_ready),
      .dup_ready        (dup_ready),
      .exec_dup_req     (exec_dup_req),
      .rob_empty        (rob_empty),
      .pipe_flush       (pipe_flush),
      .orig_accept      (orig_accept),
      .dup_issue        (dup_issue),
      .qed_exec_dup     (qed_exec_dup),
      .num_orig_insts   (num_orig_insts),
      .num_dup_insts    (num_dup_insts),
      .wait_till_commit (wait_till_commit),
      .chk_en           (chk_en),
      .abort            (abort)
   );

   typedef struct packed {
      logic [1:0] sv;
      logic       ordy, drdy, req, rob, flush;
      logic [1:0] e_acc, e_iss;
      logic       e_qed;
      logic [4:0] e_no, e_nd;
      logic       e_wtc, e_chk, e_abt;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic [1:0] sv, input logic ordy, input logic drdy,
                      input logic req, input logic rob, input logic flush,
                      input logic [1:0] eacc, input logic [1:0] eiss,
                      input logic eqed, input int eno, input int ednd,
                      input logic ewtc, input logic echk, input logic eabt);
      vec_t v;
      v.sv = sv; v.ordy = ordy; v.drdy = drdy; v.req = req; v.rob = rob;
      v.flush = flush; v.e_acc = eacc; v.e_iss = eiss; v.e_qed = eqed;
      v.e_no = eno[4:0]; v.e_nd = ednd[4:0]; v.e_wtc = ewtc; v.e_chk = echk;
      v.e_abt = eabt;
      vq.push_back(v);
   endtask

   task automatic chk_reg(input string nm, input logic eqed, input logic [4:0] eno,
                          input logic [4:0] ednd, input logic ewtc,
                          input logic echk, input logic eabt);
      checks++;
      if (qed_exec_dup !== eqed || num_orig_insts !== eno || num_dup_insts !== ednd ||
          wait_till_commit !== ewtc || chk_en !== echk || abort !== eabt) begin
         errors++;
         $display("FAIL %s: got qed=%b no=%0d nd=%0d wtc=%b chk=%b abt=%b, want qed=%b no=%0d nd=%0d wtc=%b chk=%b abt=%b",
                  nm, qed_exec_dup, num_orig_insts, num_dup_insts, wait_till_commit,
                  chk_en, abort, eqed, eno, ednd, ewtc, echk, eabt);
      end
   endtask

   // Applies queued vectors: inputs driven at posedge+1, grants checked
   // mid-cycle, registered outputs checked at the following posedge+1.
   task automatic run_queue(input string tag);
      int n;
      n = vq.size();
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v = vq[i];
         slot_valid = v.sv; orig_ready = v.ordy; dup_ready = v.drdy;
         exec_dup_req = v.req; rob_empty = v.rob; pipe_flush = v.flush;
         #1;
         checks++;
         if (orig_accept !== v.e_acc || dup_issue !== v.e_iss) begin
            errors++;
            $display("FAIL %s[%0d] grants: got acc=%b iss=%b, want acc=%b iss=%b",
                     tag, i, orig_accept, dup_issue, v.e_acc, v.e_iss);
         end
         @(posedge clk);
         #1;
         chk_reg($sformatf("%s[%0d] regs", tag, i), v.e_qed, v.e_no, v.e_nd,
                 v.e_wtc, v.e_chk, v.e_abt);
      end
      vq.delete();
      slot_valid = 2'b00; orig_ready = 1'b0; dup_ready = 1'b0;
      exec_dup_req = 1'b0; rob_empty = 1'b0; pipe_flush = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_x = 1'b0;
      slot_valid = 2'b00; orig_ready = 1'b0; dup_ready = 1'b0;
      exec_dup_req = 1'b0; rob_empty = 1'b0; pipe_flush = 1'b0;
      #17;
      chk_reg("reset_state", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      reset_x = 1'b1;
      @(posedge clk);
      #1;

      // Basic round: 4 originals, duplicates 11,11, drain 3 cycles, check.
      add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,2,0, 0,0,0);
      add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,4,0, 0,0,0);
      add(2'b00,1,0,1,0,0, 2'b00,2'b00, 1,4,0, 0,0,0);
      add(2'b11,1,1,0,0,0, 2'b00,2'b11, 1,4,2, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,4,4, 1,0,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 1,4,4, 1,0,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 1,4,4, 1,0,0);
      add(2'b00,0,0,0,1,0, 2'b00,2'b00, 1,4,4, 1,1,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      // exec_dup_req with nothing accepted is ignored.
      add(2'b00,1,0,1,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      add(2'b11,0,0,1,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      // Odd count: 3 originals, duplicates 11 then 01, rob_empty on DRAIN entry,
      // flush during CHECK ignored.
      add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,2,0, 0,0,0);
      add(2'b01,1,0,1,0,0, 2'b01,2'b00, 1,3,0, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,3,2, 0,0,0);
      add(2'b00,0,1,0,1,0, 2'b00,2'b01, 1,3,3, 1,0,0);
      add(2'b00,0,1,0,1,0, 2'b00,2'b00, 1,3,3, 1,1,0);
      add(2'b00,0,0,0,0,1, 2'b00,2'b00, 0,0,0, 0,0,0);
      // Backpressure: slot-1-only accept, dup_ready 1,0,1.
      add(2'b10,1,0,0,0,0, 2'b10,2'b00, 0,1,0, 0,0,0);
      add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,3,0, 0,0,0);
      add(2'b01,1,0,1,0,0, 2'b01,2'b00, 1,4,0, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,4,2, 0,0,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 1,4,2, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,4,4, 1,0,0);
      add(2'b00,0,0,0,1,0, 2'b00,2'b00, 1,4,4, 1,1,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      // Flush in DUP with 2 of 4 duplicates issued, then flush in ORIG.
      add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,2,0, 0,0,0);
      add(2'b11,1,0,1,0,0, 2'b11,2'b00, 1,4,0, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,4,2, 0,0,0);
      add(2'b00,0,1,0,0,1, 2'b00,2'b00, 0,0,0, 0,0,1);
      add(2'b00,0,1,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      add(2'b11,1,0,0,0,1, 2'b00,2'b00, 0,0,0, 0,0,1);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      run_queue("table");

      // Saturation: 8 cycles of two originals reach 16 and enter DUP unasked.
      for (int k = 1; k <= 8; k++)
         add(2'b11,1,0,0,0,0, 2'b11,2'b00, (k == 8),2*k,0, 0,0,0);
      add(2'b11,1,1,0,0,0, 2'b00,2'b11, 1,16,2, 0,0,0);
      for (int j = 2; j <= 8; j++)
         add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,16,2*j, (j == 8),0,0);
      add(2'b00,0,0,0,1,0, 2'b00,2'b00, 1,16,16, 1,1,0);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      run_queue("saturate");

      // Capacity boundary: at 15 only slot 0 of a valid pair fits.
      add(2'b01,1,0,0,0,0, 2'b01,2'b00, 0,1,0, 0,0,0);
      for (int k = 1; k <= 7; k++)
         add(2'b11,1,0,0,0,0, 2'b11,2'b00, 0,1+2*k,0, 0,0,0);
      add(2'b11,1,0,0,0,0, 2'b01,2'b00, 1,16,0, 0,0,0);
      add(2'b00,0,1,0,0,1, 2'b00,2'b00, 0,0,0, 0,0,1);
      add(2'b00,0,0,0,0,0, 2'b00,2'b00, 0,0,0, 0,0,0);
      run_queue("boundary");

      // Async reset mid-DRAIN, between clock edges.
      add(2'b11,1,0,1,0,0, 2'b11,2'b00, 1,2,0, 0,0,0);
      add(2'b00,0,1,0,0,0, 2'b00,2'b11, 1,2,2, 1,0,0);
      run_queue("pre_reset");
      #2;
      reset_x = 1'b0;
      #1;
      chk_reg("async_reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #3;
      reset_x = 1'b1;
      @(posedge clk);
      #1;
      add(2'b11,1,1,0,0,0, 2'b11,2'b00, 0,2,0, 0,0,0);
      add(2'b00,0,0,1,0,0, 2'b00,2'b00, 1,2,0, 0,0,0);
      run_queue("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
